// File: rtl/step_sequencer_ctrl.sv
// step_sequencer_ctrl
//   Run controller for a WIDTH-bit stepping datapath. It issues single-cycle
//   enable pulses `a` every div+1 cycles, watches the datapath value `r`, and
//   stops when `r` equals the target. The run can be paused and resumed, or
//   aborted from the paused state. After 2^WIDTH pulses without a match, the
//   run ends with an error.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   start (from IDLE) / resume (from HOLD), level
//   stop    in   pause (from RUN) / abort (from HOLD), level
//   div     in   pulse period minus 1, latched when a run starts
//   target  in   stop value for r, latched when a run starts
//   r       in   current datapath value (feedback)
//   a       out  registered enable pulse to the datapath
//   busy    out  high in RUN and HOLD
//   done    out  one-cycle completion pulse
//   err     out  qualifies done: 1 = pulse budget exhausted, no match
//
// The match check compares the r presented in the current cycle. With div=0
// and a registered datapath, the controller can issue one extra pulse before
// it sees the match. This behaviour is accepted.
module step_sequencer_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] r,
  output logic             a,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  // Pulse budget 2^WIDTH; the counter is one bit wider so it can hold it.
  localparam logic [WIDTH:0] PULSE_MAX = {1'b1, {WIDTH{1'b0}}};

  state_t           state, state_nxt;
  logic             a_nxt, done_nxt, err_nxt;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic [WIDTH:0]   pcount, pcount_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [WIDTH-1:0] tgt_q, tgt_nxt;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_nxt  = state;
    a_nxt      = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = err;
    presc_nxt  = presc;
    pcount_nxt = pcount;
    div_nxt    = div_q;
    tgt_nxt    = tgt_q;

    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_nxt  = S_RUN;
          div_nxt    = div;
          tgt_nxt    = target;
          presc_nxt  = '0;
          pcount_nxt = '0;
          err_nxt    = 1'b0;
        end
      end

      S_RUN: begin
        // Priority order: pause, match, budget, pulse, count.
        if (stop) begin
          state_nxt = S_HOLD;
        end else if (r == tgt_q) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b0;
        end else if (pcount == PULSE_MAX) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else if (presc == div_q) begin
          a_nxt      = 1'b1;
          presc_nxt  = '0;
          pcount_nxt = pcount + 1'b1;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end

      S_HOLD: begin
        // Abort takes priority over resume when both inputs are high.
        if (stop) begin
          state_nxt  = S_IDLE;
          presc_nxt  = '0;
          pcount_nxt = '0;
        end else if (start) begin
          state_nxt = S_RUN;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment, so every flop
    // samples values that were settled before the edge.
    if (rst) begin
      state  <= S_IDLE;
      a      <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      presc  <= '0;
      pcount <= '0;
      div_q  <= '0;
      tgt_q  <= '0;
    end else begin
      state  <= state_nxt;
      a      <= a_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      presc  <= presc_nxt;
      pcount <= pcount_nxt;
      div_q  <= div_nxt;
      tgt_q  <= tgt_nxt;
    end
  end

  assign busy = (state == S_RUN) || (state == S_HOLD);

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// tb_step_sequencer_ctrl
//   Self-checking bench for step_sequencer_ctrl. A behavioural reference model
//   tracks the run mode and the number of elapsed counting cycles. From these,
//   it derives the pulse times and the pulse count with plain arithmetic. The
//   bench also models a simple datapath (r increments on a, registered) so
//   that it can close the loop.
module tb_step_sequencer_ctrl;

  localparam int WIDTH  = 4;
  localparam int DIV_W  = 8;
  localparam int BUDGET = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [WIDTH-1:0] target = '0;
  logic [WIDTH-1:0] r = '0;
  logic             a, busy, done, err;

  step_sequencer_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .div    (div),
    .target (target),
    .r      (r),
    .a      (a),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit dp_inc = 1'b0;  // datapath model: 1 = r increments on each a pulse

  // Reference model: 0 idle, 1 run, 2 hold, 3 done
  int m_mode    = 0;
  int m_elapsed = 0;  // counting cycles spent in RUN since the run started
  int m_div     = 0;
  int m_tgt     = 0;
  bit m_a = 0, m_busy = 0, m_done = 0, m_err = 0;

  task automatic model_step();
    m_a    = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_mode = 0; m_elapsed = 0; m_err = 0; m_div = 0; m_tgt = 0;
    end else begin
      case (m_mode)
        0: if (start && !stop) begin
             m_mode = 1; m_div = int'(div); m_tgt = int'(target);
             m_elapsed = 0; m_err = 0;
           end
        1: if (stop) m_mode = 2;
           else if (int'(r) == m_tgt) begin m_mode = 3; m_done = 1; m_err = 0; end
           else if (m_elapsed / (m_div + 1) == BUDGET) begin
             m_mode = 3; m_done = 1; m_err = 1;
           end else begin
             m_elapsed++;
             m_a = (m_elapsed % (m_div + 1)) == 0;
           end
        2: if (stop) begin m_mode = 0; m_elapsed = 0; end
           else if (start) m_mode = 1;
        default: m_mode = 0;
      endcase
    end
    m_busy = (m_mode == 1) || (m_mode == 2);
  endtask

  // Advance one clock: step the model, apply the datapath, and sample 1 ns after the edge.
  task automatic tick();
    logic [WIDTH-1:0] r_nxt;
    model_step();
    r_nxt = (dp_inc && a) ? r + 1'b1 : r;
    @(posedge clk);
    #1;
    r = r_nxt;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; div = 8'd2; target = 4'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({a, busy, done, err} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset cyc=%0d a/busy/done/err got %b want 0000", cyc, {a, busy, done, err});
      end
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_rate();
    int first = -1, npulse = 0, misphase = 0;
    dp_inc = 0; r = 4'd0; target = 4'd5; div = 8'd3;
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL rate_busy got %b want 1", busy);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_cmp++;
      if ({a, busy, done, err} !== {m_a, m_busy, m_done, m_err}) begin
        n_bad++;
        $display("FAIL rate cyc=%0d a/busy/done/err got %b want %b", cyc,
                 {a, busy, done, err}, {m_a, m_busy, m_done, m_err});
      end
      if (a) begin
        npulse++;
        if (first < 0) first = i;
        if (i % 4 != 0) misphase++;
      end
    end
    n_cmp++;
    if (first !== 4) begin n_bad++; $display("FAIL rate_first got %0d want 4", first); end
    n_cmp++;
    if (npulse !== 5 || misphase !== 0) begin
      n_bad++; $display("FAIL rate_count got %0d pulses (%0d off-phase) want 5 (0)", npulse, misphase);
    end
    do_reset();
  endtask

  task automatic test_match();
    int npulse = 0, r3_at = -1, done_at = -1;
    bit err_at_done = 1'b1;
    dp_inc = 1; r = 4'd0; target = 4'd3; div = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      tick();
      n_cmp++;
      if ({a, busy, done, err} !== {m_a, m_busy, m_done, m_err}) begin
        n_bad++;
        $display("FAIL match cyc=%0d a/busy/done/err got %b want %b", cyc,
                 {a, busy, done, err}, {m_a, m_busy, m_done, m_err});
      end
      if (a) npulse++;
      if (r == 4'd3 && r3_at < 0) r3_at = i;
      if (done) begin done_at = i; err_at_done = err; end
    end
    n_cmp++;
    if (npulse !== 3) begin n_bad++; $display("FAIL match_pulses got %0d want 3", npulse); end
    n_cmp++;
    if (done_at < 0 || done_at !== r3_at + 1 || err_at_done !== 1'b0) begin
      n_bad++;
      $display("FAIL match_done got done_at=%0d err=%b want done_at=%0d err=0", done_at, err_at_done, r3_at + 1);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL match_idle got busy=%b done=%b want 0 0", busy, done);
    end
    dp_inc = 0;
    do_reset();
  endtask

  task automatic test_immediate();
    dp_inc = 0; r = 4'd7; target = 4'd7; div = DIV_W'($urandom_range(0, 5));
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || a !== 1'b0) begin
      n_bad++; $display("FAIL immediate_run got busy=%b a=%b want 1 0", busy, a);
    end
    tick();
    n_cmp++;
    if ({a, busy, done, err} !== 4'b0010) begin
      n_bad++; $display("FAIL immediate_done a/busy/done/err got %b want 0010", {a, busy, done, err});
    end
    tick();
    n_cmp++;
    if ({a, busy, done, err} !== 4'b0000) begin
      n_bad++; $display("FAIL immediate_idle a/busy/done/err got %b want 0000", {a, busy, done, err});
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int npulse = 0, done_at = -1;
    bit err_at_done = 1'b0;
    dp_inc = 0; r = 4'd2; target = 4'd9; div = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 60 && done_at < 0; i++) begin
      tick();
      n_cmp++;
      if ({a, busy, done, err} !== {m_a, m_busy, m_done, m_err}) begin
        n_bad++;
        $display("FAIL timeout cyc=%0d a/busy/done/err got %b want %b", cyc,
                 {a, busy, done, err}, {m_a, m_busy, m_done, m_err});
      end
      if (a) npulse++;
      if (done) begin done_at = i; err_at_done = err; end
    end
    n_cmp++;
    if (npulse !== BUDGET || done_at < 0 || err_at_done !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_end got pulses=%0d done_at=%0d err=%b want pulses=%0d err=1",
               npulse, done_at, err_at_done, BUDGET);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_idle got busy=%b done=%b err=%b want 0 0 1", busy, done, err);
    end
    do_reset();
  endtask

  task automatic test_pause_resume();
    int npulse = 0, gap = -1, held_bad = 0;
    dp_inc = 0; r = 4'd0; target = 4'd15; div = 8'd2;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && npulse < 2; i++) begin
      tick();
      if (a) npulse++;
    end
    tick();                       // prescaler advances to 1 after the 2nd pulse
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a !== 1'b0 || busy !== 1'b1 || {a, busy, done, err} !== {m_a, m_busy, m_done, m_err}) held_bad++;
    end
    n_cmp++;
    if (npulse !== 2 || held_bad !== 0) begin
      n_bad++; $display("FAIL hold got pulses=%0d bad_hold_cycles=%0d want 2 0", npulse, held_bad);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 10 && gap < 0; i++) begin
      tick();
      if (a) gap = i;
    end
    n_cmp++;
    if (gap !== 2) begin n_bad++; $display("FAIL resume_phase got gap=%0d want 2", gap); end
    // pause then abort
    stop = 1'b1; tick(); tick(); stop = 1'b0;
    n_cmp++;
    if ({a, busy, done, err} !== 4'b0000) begin
      n_bad++; $display("FAIL abort a/busy/done/err got %b want 0000", {a, busy, done, err});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL abort_quiet got busy=%b done=%b want 0 0", busy, done);
      end
    end
    // start+stop together in HOLD aborts
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || {m_busy, m_done} !== 2'b00) begin
      n_bad++; $display("FAIL both_in_hold got busy=%b done=%b want 0 0", busy, done);
    end
    do_reset();
  endtask

  task automatic test_reset_midrun();
    int waited = 0, npulse = 0, done_at = -1;
    dp_inc = 0; r = 4'd0; target = 4'd15; div = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    while (a !== 1'b1 && waited < 10) begin tick(); waited++; end
    n_cmp++;
    if (a !== 1'b1) begin n_bad++; $display("FAIL midrun_wait got a=%b want 1", a); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if ({a, busy, done, err} !== 4'b0000) begin
      n_bad++; $display("FAIL midrun_reset a/busy/done/err got %b want 0000", {a, busy, done, err});
    end
    dp_inc = 1; r = 4'd0; target = 4'd4; div = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    div = 8'd0; target = 4'd9;    // changes while busy have no effect
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      tick();
      n_cmp++;
      if ({a, busy, done, err} !== {m_a, m_busy, m_done, m_err}) begin
        n_bad++;
        $display("FAIL relatch cyc=%0d a/busy/done/err got %b want %b", cyc,
                 {a, busy, done, err}, {m_a, m_busy, m_done, m_err});
      end
      if (a) npulse++;
      if (done) done_at = i;
    end
    n_cmp++;
    if (npulse !== 4 || done_at < 0) begin
      n_bad++; $display("FAIL relatch_pulses got %0d done_at=%0d want 4 pulses and done", npulse, done_at);
    end
    dp_inc = 0;
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) dp_inc = $urandom_range(0, 1) == 1;
      rst    = $urandom_range(0, 199) == 0;
      start  = $urandom_range(0, 7) == 0;
      stop   = $urandom_range(0, 15) == 0;
      div    = DIV_W'($urandom_range(0, 3));
      target = WIDTH'($urandom);
      if (!dp_inc && $urandom_range(0, 31) == 0) r = WIDTH'($urandom);
      tick();
      n_cmp++;
      if ({a, busy, done, err} !== {m_a, m_busy, m_done, m_err}) begin
        n_bad++;
        $display("FAIL random cyc=%0d a/busy/done/err got %b want %b", cyc,
                 {a, busy, done, err}, {m_a, m_busy, m_done, m_err});
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; dp_inc = 0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_rate();
    test_match();
    test_immediate();
    test_timeout();
    test_pause_resume();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
